// File: rtl/data_mem_server.sv
// Shared single-port data memory for NUM_CORES cores. A round-robin arbiter grants
// one request per clock, and the ack and read data are registered one cycle after the grant.
module data_mem_server #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        write_en,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_data,
  input  logic [NUM_CORES*DATA_W-1:0] datain,
  output logic [NUM_CORES*DATA_W-1:0] dataout,
  output logic [NUM_CORES-1:0]        ack,
  output logic                        busy
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] elig_p0;
  logic                 gnt_vld_p0;
  logic [PTR_W-1:0]     gnt_idx_p0;
  logic                 gnt_we_p0;
  logic [ADDR_W-1:0]    gnt_addr_p0;
  logic [DATA_W-1:0]    gnt_wdata_p0;
  logic                 in_range_p0;
  logic [IDX_W-1:0]     ram_idx_p0;
  logic [DATA_W-1:0]    rd_word_p0;

  // Stage p0: arbitration and RAM access. A port whose ack is high this cycle
  // is already served, so it is masked even if its core still holds req.
  assign elig_p0 = req & ~ack;

  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_CORES;
      cand_idx = PTR_W'(cand);
      if (!gnt_vld_p0 && elig_p0[cand_idx]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand_idx;
      end
    end
    if (reset) gnt_vld_p0 = 1'b0;
  end

  assign gnt_we_p0    = write_en[gnt_idx_p0];
  assign gnt_addr_p0  = addr_data[gnt_idx_p0*ADDR_W +: ADDR_W];
  assign gnt_wdata_p0 = datain[gnt_idx_p0*DATA_W +: DATA_W];
  assign in_range_p0  = (32'(gnt_addr_p0) < 32'(DEPTH));
  assign ram_idx_p0   = gnt_addr_p0[IDX_W-1:0];
  assign rd_word_p0   = in_range_p0 ? ram[ram_idx_p0] : '0;

  always_ff @(posedge clock) begin
    if (gnt_vld_p0 && gnt_we_p0 && in_range_p0)
      ram[ram_idx_p0] <= gnt_wdata_p0;
  end

  // Stage p1: registered ack, busy and per-port read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr  <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      dataout <= '0;
    end else begin
      ack  <= '0;
      busy <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        ack[gnt_idx_p0] <= 1'b1;
        rr_ptr          <= PTR_W'((int'(gnt_idx_p0) + 1) % NUM_CORES);
        if (!gnt_we_p0)
          dataout[gnt_idx_p0*DATA_W +: DATA_W] <= rd_word_p0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_server.sv
// Directed bench for data_mem_server: 4 cores, 9-bit addresses, 256 implemented words.
module tb_data_mem_server;

  localparam int NC = 4;
  localparam int AW = 9;
  localparam int DW = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NC-1:0]    req = '0;
  logic [NC-1:0]    write_en = '0;
  logic [NC*AW-1:0] addr_data = '0;
  logic [NC*DW-1:0] datain = '0;
  logic [NC*DW-1:0] dataout;
  logic [NC-1:0]    ack;
  logic             busy;

  int errors = 0;
  int checks = 0;

  data_mem_server #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .DEPTH(256)) dut (
    .clock(clock), .reset(reset), .req(req), .write_en(write_en),
    .addr_data(addr_data), .datain(datain), .dataout(dataout),
    .ack(ack), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[p]             = 1'b1;
    write_en[p]        = we;
    addr_data[p*AW+:AW] = a;
    datain[p*DW+:DW]   = d;
  endtask

  task automatic clr_req(input int p);
    req[p] = 1'b0;
  endtask

  function automatic logic [DW-1:0] dout(input int p);
    return dataout[p*DW+:DW];
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (dataout !== '0) begin errors++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
    reset = 1'b0;
  endtask

  // rr_ptr=0: core 0 write then read back.
  task automatic test_write_read();
    set_req(0, 1'b1, 9'h010, 16'h1234);
    tick();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL wr_ack: got %b expected 0001", ack); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy); end
    checks++;
    if (dout(0) !== 16'h0000) begin errors++; $display("FAIL wr_dout_hold: got %h expected 0000", dout(0)); end
    clr_req(0);
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_wr: got ack=%b busy=%b expected 0000/0", ack, busy);
    end
    set_req(0, 1'b0, 9'h010, 16'h0000);
    tick();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL rd_ack: got %b expected 0001", ack); end
    checks++;
    if (dout(0) !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h expected 1234", dout(0)); end
    clr_req(0);
    tick();
  endtask

  task automatic test_all_four();
    pulse_reset();
    for (int p = 0; p < NC; p++) set_req(p, 1'b0, 9'h010, 16'h0000);
    for (int i = 0; i < NC; i++) begin
      tick();
      checks++;
      if (ack !== (4'b0001 << i)) begin
        errors++; $display("FAIL rr4_ack%0d: got %b expected %b", i, ack, 4'b0001 << i);
      end
      checks++;
      if (dout(i) !== 16'h1234) begin
        errors++; $display("FAIL rr4_data%0d: got %h expected 1234", i, dout(i));
      end
      clr_req(i);
    end
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rr4_idle: got ack=%b busy=%b expected 0000/0", ack, busy);
    end
  endtask

  // rr_ptr=0 entering; cores 1 and 3 never drop req.
  task automatic test_back_to_back();
    logic [NC-1:0] exp;
    set_req(1, 1'b0, 9'h010, 16'h0000);
    set_req(3, 1'b0, 9'h010, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c % 2 == 1) ? 4'b0010 : 4'b1000;
      checks++;
      if (ack !== exp || busy !== 1'b1) begin
        errors++; $display("FAIL alt_cycle%0d: got ack=%b busy=%b expected %b/1", c, ack, busy, exp);
      end
    end
    clr_req(1);
    clr_req(3);
    tick();
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL alt_idle: got %b expected 0000", ack); end
  endtask

  // rr_ptr=0 entering; only core 2 active.
  task automatic test_out_of_range();
    set_req(2, 1'b1, 9'h0F5, 16'h5555);
    tick();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL oor_wr0_ack: got %b expected 0100", ack); end
    checks++;
    if (dout(2) !== 16'h1234) begin errors++; $display("FAIL oor_hold: got %h expected 1234", dout(2)); end
    clr_req(2);
    tick();
    set_req(2, 1'b1, 9'h1F5, 16'hAAAA);
    tick();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL oor_wr1_ack: got %b expected 0100", ack); end
    clr_req(2);
    tick();
    set_req(2, 1'b0, 9'h1F5, 16'h0000);
    tick();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL oor_rd_ack: got %b expected 0100", ack); end
    checks++;
    if (dout(2) !== 16'h0000) begin errors++; $display("FAIL oor_rd_data: got %h expected 0000", dout(2)); end
    clr_req(2);
    tick();
    set_req(2, 1'b0, 9'h0F5, 16'h0000);
    tick();
    checks++;
    if (dout(2) !== 16'h5555) begin errors++; $display("FAIL oor_alias: got %h expected 5555", dout(2)); end
    clr_req(2);
    tick();
  endtask

  // rr_ptr=3 entering, so core 1 is granted and rr_ptr moves to 2 before reset.
  task automatic test_reset_midop();
    set_req(1, 1'b0, 9'h0F5, 16'h0000);
    tick();
    checks++;
    if (ack !== 4'b0010 || dout(1) !== 16'h5555) begin
      errors++; $display("FAIL rst_pre: got ack=%b d1=%h expected 0010/5555", ack, dout(1));
    end
    clr_req(1);
    reset = 1'b1;
    set_req(0, 1'b0, 9'h010, 16'h0000);
    set_req(3, 1'b0, 9'h010, 16'h0000);
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || dout(1) !== 16'h0000) begin
      errors++; $display("FAIL rst_mid: got ack=%b busy=%b d1=%h expected 0000/0/0000", ack, busy, dout(1));
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0001 || dout(0) !== 16'h1234) begin
      errors++; $display("FAIL rst_first: got ack=%b d0=%h expected 0001/1234", ack, dout(0));
    end
    clr_req(0);
    tick();
    checks++;
    if (ack !== 4'b1000 || dout(3) !== 16'h1234) begin
      errors++; $display("FAIL rst_second: got ack=%b d3=%h expected 1000/1234", ack, dout(3));
    end
    clr_req(3);
    tick();
  endtask

  // rr_ptr=0 entering: write from core 0 is ordered before core 3's read.
  task automatic test_write_then_read();
    set_req(0, 1'b1, 9'h020, 16'hBEEF);
    set_req(3, 1'b0, 9'h020, 16'h0000);
    tick();
    checks++;
    if (ack !== 4'b0001 || dout(0) !== 16'h1234) begin
      errors++; $display("FAIL raw_wr: got ack=%b d0=%h expected 0001/1234", ack, dout(0));
    end
    clr_req(0);
    tick();
    checks++;
    if (ack !== 4'b1000 || dout(3) !== 16'hBEEF) begin
      errors++; $display("FAIL raw_rd: got ack=%b d3=%h expected 1000/beef", ack, dout(3));
    end
    clr_req(3);
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL raw_idle: got ack=%b busy=%b expected 0000/0", ack, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_four();
    test_back_to_back();
    test_out_of_range();
    test_reset_midop();
    test_write_then_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
